chan_router: RTL and testbench
==============================

Name: chan_router

Overview:
- Parametrised, registered successor to the 4x4-bit switch mux/demux path.
- Routes any one of NCH input channels of W bits to any one of NCH output channels.
- Source and destination selects are held in internal registers, not driven combinationally from buttons. They are advanced by step pulses or loaded directly.
- Sits between board switch banks and LED banks, or between any two multi-channel datapaths.

Parameters:
- NCH, 4: number of input and output channels; must be >= 2.
- W, 4: bits per channel; must be >= 1.
- HOLD, 0: 0 = unselected outputs forced to zero; 1 = unselected outputs keep their last value.
- SELW, $clog2(NCH): select width. Derived; must not be overridden.

Ports:
- clk, input, 1: system clock. All state changes on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: routing enable.
- din, input, NCH*W: input channels; channel k occupies bits [k*W +: W].
- src_step, input, 1: advance source select by one.
- dst_step, input, 1: advance destination select by one.
- sel_load, input, 1: load both selects directly.
- src_val, input, SELW: source value used by sel_load.
- dst_val, input, SELW: destination value used by sel_load.
- dout, output, NCH*W: output channels; same packing as din.
- src_sel, output, SELW: current source select register.
- dst_sel, output, SELW: current destination select register.
- route_valid, output, 1: dout reflects a route taken on the previous edge.

Behaviour:
- Reset, with rst high at the clock edge:
  - src_sel = 0, dst_sel = 0.
  - dout = all zeros, route_valid = 0.
  - Edge-detect history registers cleared.
  - rst overrides every other input. Asserting it mid-operation clears all of the above on that edge, regardless of HOLD.
- Routing, on each edge with en = 1:
  - dout channel dst_sel <= din channel src_sel.
  - Uses the select values present before this edge's select update.
  - Other channels are cleared to 0 when HOLD = 0 and unchanged when HOLD = 1.
  - route_valid <= 1.
- Latency: din to dout is exactly 1 cycle. A select change made on edge N first affects dout on edge N+1.
- Routing with en = 0: route_valid <= 0. All dout cleared when HOLD = 0; all dout held when HOLD = 1. The select registers still update; selects are independent of en.
- Select update priority on each edge: rst, then sel_load, then step.
  - sel_load = 1: src_sel <= min(src_val, NCH-1) and dst_sel <= min(dst_val, NCH-1). Out-of-range values saturate. Steps on the same edge are ignored.
  - Otherwise a step event on src or dst increments that select. The value wraps from NCH-1 to 0, including when NCH is not a power of two.
  - src and dst steps on the same edge are both applied independently.
- src_sel == dst_sel indices are unrelated namespaces; no special case.
- Idle channel behaviour follows HOLD only; there is no default-route channel.

Optional Feature:
- Macro: CHAN_ROUTER_STEP_EDGE_EN.
- Defined:
  - src_step and dst_step are registered once.
  - A step event is a rising edge: current = 1 and previous = 0.
  - A step held high for many cycles advances the select exactly once.
  - The event is applied on the edge after the input is first sampled high, adding 1 cycle of latency versus undefined.
  - History registers reset to 0, so a step input already high when rst deasserts counts as one event.
- Undefined:
  - A step event is any edge where the step input is 1, so each high cycle advances by one.
  - Callers must supply single-cycle pulses, e.g. from an external debouncer.

Test Plan:
- Reset: NCH=4, W=4, drive garbage, hold rst 2 cycles -> dout=0x0000, src_sel=0, dst_sel=0, route_valid=0.
- Basic route: din=0xF3A5, en=1, sel_load with src_val=2, dst_val=1 -> one edge later selects=2/1; next edge dout=0x0030 (HOLD=0), route_valid=1.
- Wrap: NCH=3, src_sel=2, single src_step pulse -> src_sel=0. sel_load src_val=3 -> src_sel=2 (saturated).
- HOLD=1: route 0x5 to out0, then change dst to 3 with din ch0=0x9 -> dout=0x9005. Drop en -> dout stays 0x9005, route_valid=0.
- Priority: sel_load=1 with src_step=1 and dst_step=1 on same edge, src_val=1, dst_val=0 -> selects exactly 1/0. rst mid-stream with HOLD=1 -> dout=0.
- With CHAN_ROUTER_STEP_EDGE_EN: hold src_step high 10 cycles from src_sel=0 -> src_sel=1 only. Without macro: same stimulus -> src_sel=10 mod NCH (2 for NCH=4).

Source files
------------

// File: rtl/chan_router.sv
// Registered NCH x W channel router: one source channel to one destination channel per cycle.
// Optional macro CHAN_ROUTER_STEP_EDGE_EN turns the step inputs into rising-edge events.
module chan_router #(
  parameter int NCH  = 4,
  parameter int W    = 4,
  parameter int HOLD = 0,
  localparam int SELW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NCH*W-1:0]  din,
  input  logic              src_step,
  input  logic              dst_step,
  input  logic              sel_load,
  input  logic [SELW-1:0]   src_val,
  input  logic [SELW-1:0]   dst_val,
  output logic [NCH*W-1:0]  dout,
  output logic [SELW-1:0]   src_sel,
  output logic [SELW-1:0]   dst_sel,
  output logic              route_valid
);

  localparam logic [SELW-1:0] MAXSEL = SELW'(NCH - 1);

  logic            src_ev;
  logic            dst_ev;
  logic [SELW-1:0] src_lim;
  logic [SELW-1:0] dst_lim;
  logic [SELW-1:0] src_inc;
  logic [SELW-1:0] dst_inc;
  logic [W-1:0]    pick;

`ifdef CHAN_ROUTER_STEP_EDGE_EN
  // Steps are sampled once, then compared against the previous sample.
  logic src_q, src_qq, dst_q, dst_qq;

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q  <= 1'b0;
      src_qq <= 1'b0;
      dst_q  <= 1'b0;
      dst_qq <= 1'b0;
    end else begin
      src_q  <= src_step;
      src_qq <= src_q;
      dst_q  <= dst_step;
      dst_qq <= dst_q;
    end
  end

  assign src_ev = src_q & ~src_qq;
  assign dst_ev = dst_q & ~dst_qq;
`else
  assign src_ev = src_step;
  assign dst_ev = dst_step;
`endif

  assign src_lim = (src_val > MAXSEL) ? MAXSEL : src_val;
  assign dst_lim = (dst_val > MAXSEL) ? MAXSEL : dst_val;
  // Explicit wrap so non-power-of-two NCH never reaches an unused code.
  assign src_inc = (src_sel == MAXSEL) ? '0 : src_sel + SELW'(1);
  assign dst_inc = (dst_sel == MAXSEL) ? '0 : dst_sel + SELW'(1);

  always_comb begin
    pick = '0;
    for (int k = 0; k < NCH; k++) begin
      if (src_sel == SELW'(k)) pick = din[k*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout        <= '0;
      route_valid <= 1'b0;
      src_sel     <= '0;
      dst_sel     <= '0;
    end else begin
      route_valid <= en;
      for (int k = 0; k < NCH; k++) begin
        if (en && (dst_sel == SELW'(k))) begin
          dout[k*W +: W] <= pick;
        end else if (HOLD == 0) begin
          dout[k*W +: W] <= '0;
        end
      end
      if (sel_load) begin
        src_sel <= src_lim;
        dst_sel <= dst_lim;
      end else begin
        if (src_ev) src_sel <= src_inc;
        if (dst_ev) dst_sel <= dst_inc;
      end
    end
  end

endmodule

// File: tb/tb_chan_router.sv
// Bench for chan_router: three instances (NCH=4/HOLD=0, NCH=3/HOLD=0, NCH=4/HOLD=1) on shared stimulus.
module tb_chan_router;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        ss = 1'b0;
  logic        ds = 1'b0;
  logic        ld = 1'b0;
  logic [1:0]  sv = '0;
  logic [1:0]  dv = '0;
  logic [15:0] din = '0;
  logic [11:0] din_b;

  logic [15:0] dout_a, dout_c;
  logic [11:0] dout_b;
  logic [1:0]  src_a, dst_a, src_b, dst_b, src_c, dst_c;
  logic        val_a, val_b, val_c;

  int n_assert = 0;
  int n_fail   = 0;

  assign din_b = din[11:0];

  always #5 clk = ~clk;

  chan_router #(.NCH(4), .W(4), .HOLD(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .din(din), .src_step(ss), .dst_step(ds),
    .sel_load(ld), .src_val(sv), .dst_val(dv), .dout(dout_a),
    .src_sel(src_a), .dst_sel(dst_a), .route_valid(val_a));

  chan_router #(.NCH(3), .W(4), .HOLD(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .din(din_b), .src_step(ss), .dst_step(ds),
    .sel_load(ld), .src_val(sv), .dst_val(dv), .dout(dout_b),
    .src_sel(src_b), .dst_sel(dst_b), .route_valid(val_b));

  chan_router #(.NCH(4), .W(4), .HOLD(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .din(din), .src_step(ss), .dst_step(ds),
    .sel_load(ld), .src_val(sv), .dst_val(dv), .dout(dout_c),
    .src_sel(src_c), .dst_sel(dst_c), .route_valid(val_c));

  typedef struct {
    string       name;
    bit          chk;
    int          unit;
    bit          rst, en, ss, ds, ld;
    logic [1:0]  sv, dv;
    logic [15:0] din;
    logic [15:0] e_dout;
    logic [1:0]  e_src, e_dst;
    bit          e_val;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(string name, bit chk, int unit, bit r, bit e, bit s1, bit s2,
                              bit l, logic [1:0] a, logic [1:0] b, logic [15:0] d,
                              logic [15:0] ed, logic [1:0] es, logic [1:0] et, bit ev);
    vec_t v;
    v.name = name; v.chk = chk; v.unit = unit;
    v.rst = r; v.en = e; v.ss = s1; v.ds = s2; v.ld = l;
    v.sv = a; v.dv = b; v.din = d;
    v.e_dout = ed; v.e_src = es; v.e_dst = et; v.e_val = ev;
    return v;
  endfunction

  task automatic cmp(string name, logic [15:0] act, logic [15:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    vec_t e;
    logic [15:0] a_dout;
    logic [1:0]  a_src, a_dst;
    logic        a_val;
    @(negedge clk);
    rst = v.rst; en = v.en; ss = v.ss; ds = v.ds; ld = v.ld;
    sv = v.sv; dv = v.dv; din = v.din;
    if (v.chk) sb.push_back(v);
    @(posedge clk);
    #1;
    if (v.chk) begin
      if (sb.size() == 0) begin
        n_assert++; n_fail++;
        $display("FAIL %s: scoreboard empty", v.name);
      end else begin
        e = sb.pop_front();
        case (e.unit)
          0:       begin a_dout = dout_a;         a_src = src_a; a_dst = dst_a; a_val = val_a; end
          1:       begin a_dout = {4'h0, dout_b}; a_src = src_b; a_dst = dst_b; a_val = val_b; end
          default: begin a_dout = dout_c;         a_src = src_c; a_dst = dst_c; a_val = val_c; end
        endcase
        cmp({e.name, ".dout"}, a_dout, e.e_dout);
        cmp({e.name, ".src_sel"}, {14'h0, a_src}, {14'h0, e.e_src});
        cmp({e.name, ".dst_sel"}, {14'h0, a_dst}, {14'h0, e.e_dst});
        cmp({e.name, ".valid"}, {15'h0, a_val}, {15'h0, e.e_val});
      end
    end
  endtask

  task automatic idle(int unit, bit chk, string name, logic [15:0] ed,
                      logic [1:0] es, logic [1:0] et);
    apply(mk(name, chk, unit, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'h0, ed, es, et, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] held_exp;
`ifdef CHAN_ROUTER_STEP_EDGE_EN
    held_exp = 2'd1;
`else
    held_exp = 2'd2;
`endif

    //                 name         chk u rst en ss ds ld  sv    dv    din       dout      src   dst   val
    tbl.push_back(mk("rst0",       1, 0, 1, 1, 0, 0, 1, 2'd3, 2'd3, 16'hFFFF, 16'h0000, 2'd0, 2'd0, 0));
    tbl.push_back(mk("rst1",       1, 0, 1, 1, 1, 1, 0, 2'd3, 2'd3, 16'hFFFF, 16'h0000, 2'd0, 2'd0, 0));
    tbl.push_back(mk("load21",     1, 0, 0, 1, 0, 0, 1, 2'd2, 2'd1, 16'hF3A5, 16'h0005, 2'd2, 2'd1, 1));
    tbl.push_back(mk("route21",    1, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 16'hF3A5, 16'h0030, 2'd2, 2'd1, 1));
    tbl.push_back(mk("route21b",   1, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 16'h1234, 16'h0020, 2'd2, 2'd1, 1));
    tbl.push_back(mk("en_off",     1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'h1234, 16'h0000, 2'd2, 2'd1, 0));
    tbl.push_back(mk("load_en0",   1, 0, 0, 0, 0, 0, 1, 2'd3, 2'd0, 16'h1234, 16'h0000, 2'd3, 2'd0, 0));
    tbl.push_back(mk("route30",    1, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 16'h1234, 16'h0001, 2'd3, 2'd0, 1));
    tbl.push_back(mk("old_sel",    1, 0, 0, 1, 0, 0, 1, 2'd0, 2'd3, 16'hABCD, 16'h000A, 2'd0, 2'd3, 1));
    tbl.push_back(mk("route03",    1, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 16'hABCD, 16'hD000, 2'd0, 2'd3, 1));
    tbl.push_back(mk("prio_ld",    1, 0, 0, 0, 1, 1, 1, 2'd1, 2'd0, 16'h1234, 16'h0000, 2'd1, 2'd0, 0));
    tbl.push_back(mk("prio_ld2",   1, 0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 16'h1234, 16'h0000, 2'd1, 2'd0, 0));
    tbl.push_back(mk("route10",    1, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 16'h1234, 16'h0003, 2'd1, 2'd0, 1));
    tbl.push_back(mk("rst_mid",    1, 0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 16'h1234, 16'h0000, 2'd0, 2'd0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Step held high for ten cycles on the NCH=4 instance.
    for (int i = 0; i < 10; i++)
      apply(mk("held", 0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 16'h0, 16'h0, 2'd0, 2'd0, 0));
    idle(0, 0, "held_idle", 16'h0, 2'd0, 2'd0);
    idle(0, 1, "held_step", 16'h0, held_exp, 2'd0);

    // Simultaneous single-cycle src and dst pulses.
    apply(mk("both_rst", 1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 16'h0, 16'h0, 2'd0, 2'd0, 0));
    apply(mk("both_pls", 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 16'h0, 16'h0, 2'd0, 2'd0, 0));
    idle(0, 0, "both_idle", 16'h0, 2'd0, 2'd0);
    idle(0, 1, "both_step", 16'h0, 2'd1, 2'd1);

    // NCH=3: wrap and saturation.
    apply(mk("b_rst",   1, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 16'h0, 16'h0, 2'd0, 2'd0, 0));
    apply(mk("b_ld20",  1, 1, 0, 0, 0, 0, 1, 2'd2, 2'd0, 16'h0, 16'h0, 2'd2, 2'd0, 0));
    apply(mk("b_spls",  0, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0, 16'h0, 16'h0, 2'd0, 2'd0, 0));
    idle(1, 0, "b_idle", 16'h0, 2'd0, 2'd0);
    idle(1, 1, "b_swrap", 16'h0, 2'd0, 2'd0);
    apply(mk("b_sat",   1, 1, 0, 0, 0, 0, 1, 2'd3, 2'd3, 16'h0, 16'h0, 2'd2, 2'd2, 0));
    apply(mk("b_rt22",  1, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 16'h0ABC, 16'h0A00, 2'd2, 2'd2, 1));
    apply(mk("b_dpls",  0, 1, 0, 0, 0, 1, 0, 2'd0, 2'd0, 16'h0, 16'h0, 2'd0, 2'd0, 0));
    idle(1, 0, "b_idle2", 16'h0, 2'd0, 2'd0);
    apply(mk("b_rt20",  1, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 16'h0ABC, 16'h000A, 2'd2, 2'd0, 1));

    // HOLD=1: unselected and disabled outputs keep their value; reset still clears.
    apply(mk("c_rst",   1, 2, 1, 0, 0, 0, 0, 2'd0, 2'd0, 16'h0, 16'h0, 2'd0, 2'd0, 0));
    apply(mk("c_rt00",  1, 2, 0, 1, 0, 0, 0, 2'd0, 2'd0, 16'h0005, 16'h0005, 2'd0, 2'd0, 1));
    apply(mk("c_ld03",  1, 2, 0, 0, 0, 0, 1, 2'd0, 2'd3, 16'hFFFF, 16'h0005, 2'd0, 2'd3, 0));
    apply(mk("c_rt03",  1, 2, 0, 1, 0, 0, 0, 2'd0, 2'd0, 16'h0009, 16'h9005, 2'd0, 2'd3, 1));
    apply(mk("c_en0",   1, 2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'hFFFF, 16'h9005, 2'd0, 2'd3, 0));
    apply(mk("c_rst2",  1, 2, 1, 1, 0, 0, 0, 2'd0, 2'd0, 16'hFFFF, 16'h0000, 2'd0, 2'd0, 0));

    if (sb.size() != 0) begin
      n_assert++; n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
